pwm_ctrl: RTL and testbench
===========================

Name: pwm_ctrl

Overview:
Control stage for the PWM datapath. It holds the 8-bit period counter register (COUNTER_Q) and drives the datapath's MUX_SEL. It takes the datapath's next-count value (COUNTER_D) back in. From the counter and the period/duty settings it produces the PWM output. Period and duty are loaded through a valid/ready handshake into a shadow register and applied only at period boundaries, so the output never glitches.

Parameters:
WIDTH, 8, counter/period/duty width; must equal the datapath counter width.

Ports:
CLK  input  1  system clock; all state updates on the rising edge
RST_N  input  1  synchronous reset, active-low
EN  input  1  run enable
CFG_VALID  input  1  new period/duty offered
CFG_READY  output  1  shadow register free; transfer occurs when CFG_VALID && CFG_READY
CFG_PERIOD  input  WIDTH  period value P; cycle length is P+1 clocks
CFG_DUTY  input  WIDTH  duty value D; output is high while count < D
COUNTER_D  input  WIDTH  next count from datapath (COUNTER_Q+1 when MUX_SEL=01, else 0)
COUNTER_Q  output  WIDTH  registered counter, fed to datapath
MUX_SEL  output  2  datapath select: 01 = increment, 00 = clear; 10/11 never driven
PWM_OUT  output  1  PWM signal
CYCLE_END  output  1  high during the last count of each period

Behaviour:
- Reset (RST_N=0 at an edge): everything below takes its reset value on that edge, including mid-period.
  - state IDLE; COUNTER_Q 0.
  - Active P/D 0; pending P/D 0; loaded flag 0; pending flag 0.
  - Resulting outputs: MUX_SEL 00, PWM_OUT 0, CYCLE_END 0, CFG_READY 1.
- Every edge: COUNTER_Q <= COUNTER_D. The datapath is the only source of the next count.
- CFG_READY = !pending flag.
- On accept: pending P/D <= CFG_PERIOD/CFG_DUTY; pending flag set.
- Pending-to-active transfer (active P/D <= pending, loaded set, pending cleared) happens on either:
  - any edge while in IDLE; or
  - the wrap edge in RUN (COUNTER_Q == active P).
- An accept in the same cycle as a transfer only loads pending. It is applied at the next transfer opportunity.
- FSM states:
  - IDLE:
    - MUX_SEL=00; PWM_OUT=0; CYCLE_END=0.
    - Go to RUN when EN=1 and loaded=1, evaluated with registered loaded, so the earliest entry is one cycle after transfer.
    - The first RUN cycle has COUNTER_Q=0.
  - RUN:
    - MUX_SEL = (COUNTER_Q == active P) ? 00 : 01.
    - CYCLE_END = (COUNTER_Q == active P).
    - PWM_OUT = (COUNTER_Q < active D).
    - At the wrap edge: go to IDLE if EN=0, else stay in RUN.
    - EN deassert mid-period lets the current period finish.
- PWM_OUT, MUX_SEL and CYCLE_END are decoded from registered state only; no input-to-output combinational path.
- Boundaries:
  - D=0: PWM_OUT constantly 0.
  - D > P: PWM_OUT constantly 1 in RUN.
  - P=0: counter stays 0, MUX_SEL 00 every cycle, CYCLE_END every RUN cycle, PWM_OUT = (D != 0).
  - P=255: 256-clock period; the counter never reaches wrap-around by the increment path.
- Comparisons are unsigned, WIDTH bits.
- Latency: config accepted during a period takes effect at the period following its wrap edge.

Test Plan:
1. Hold RST_N=0 for 2 cycles, EN=1, no config -> COUNTER_Q=0, MUX_SEL=00, PWM_OUT=0, CYCLE_END=0, CFG_READY=1. The block stays in IDLE after release.
2. Load P=4, D=2, EN=1 -> the RUN pattern repeats every 5 cycles:
   - COUNTER_Q 0,1,2,3,4
   - PWM_OUT 1,1,0,0,0
   - MUX_SEL 01,01,01,01,00
   - CYCLE_END 0,0,0,0,1
3. While running P=4, D=2, offer D=4 at COUNTER_Q=1 ->
   - CFG_READY low from the next cycle until the cycle after the wrap.
   - The current period is unchanged.
   - The next period's PWM_OUT is 1,1,1,1,0.
   - A second offer during the same period is stalled (CFG_READY=0).
4. Edge settings:
   - D=0, P=4 -> PWM_OUT always 0.
   - D=9, P=4 -> PWM_OUT always 1.
   - P=0, D=1 -> COUNTER_Q stays 0, MUX_SEL=00, CYCLE_END=1 every cycle, PWM_OUT=1.
5. Running P=4, drop EN at COUNTER_Q=2 -> counts continue through 3,4 (CYCLE_END at 4), then IDLE with COUNTER_Q=0, PWM_OUT=0. Re-asserting EN restarts at count 0 with the same config.
6. RST_N=0 for one cycle at COUNTER_Q=3 in RUN -> next cycle COUNTER_Q=0, PWM_OUT=0, state IDLE, loaded=0. EN=1 does not restart until a new config is accepted.

Source files
------------

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: control stage of the PWM datapath.
// Owns the period counter register, steers the datapath mux, and decodes
// PWM_OUT / CYCLE_END from registered state only. Period/duty arrive via a
// valid/ready handshake into a shadow register and reach the active settings
// only at a period boundary (or while idle), so a period is never cut short
// or reshaped midway.
//
// Handshake: a transfer happens on a rising edge where CFG_VALID && CFG_READY.
// CFG_READY depends only on registered state (shadow register empty), never
// on CFG_VALID; the source holds CFG_PERIOD/CFG_DUTY stable while VALID is
// high and not yet accepted.
module pwm_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             CFG_VALID,
  output logic             CFG_READY,
  input  logic [WIDTH-1:0] CFG_PERIOD,
  input  logic [WIDTH-1:0] CFG_DUTY,
  input  logic [WIDTH-1:0] COUNTER_D,
  output logic [WIDTH-1:0] COUNTER_Q,
  output logic [1:0]       MUX_SEL,
  output logic             PWM_OUT,
  output logic             CYCLE_END,
  output logic             state_dbg
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_INCR  = 2'b01;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] act_period_q;
  logic [WIDTH-1:0] act_duty_q;
  logic [WIDTH-1:0] pend_period_q;
  logic [WIDTH-1:0] pend_duty_q;
  logic             loaded_q;
  logic             pending_q;

  logic             at_wrap;
  logic             accept;
  logic             transfer;

  // The last count of a period; only meaningful while running.
  assign at_wrap  = (state_q == RUN) && (count_q == act_period_q);
  // Shadow register is free exactly when nothing is pending, so an accept and
  // a transfer never coincide; an accept always lands in the shadow register.
  assign accept   = CFG_VALID && !pending_q;
  assign transfer = pending_q && ((state_q == IDLE) || at_wrap);

  assign CFG_READY = !pending_q;
  assign COUNTER_Q = count_q;
  assign state_dbg = state_q;

  // State register; the counter always follows the datapath's next count.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= COUNTER_D;
    end
  end

  // Shadow register capture and shadow-to-active transfer.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      act_period_q  <= '0;
      act_duty_q    <= '0;
      pend_period_q <= '0;
      pend_duty_q   <= '0;
      loaded_q      <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      if (transfer) begin
        act_period_q <= pend_period_q;
        act_duty_q   <= pend_duty_q;
        loaded_q     <= 1'b1;
        pending_q    <= 1'b0;
      end
      if (accept) begin
        pend_period_q <= CFG_PERIOD;
        pend_duty_q   <= CFG_DUTY;
        pending_q     <= 1'b1;
      end
    end
  end

  // Next-state and output decode from registered state only.
  always_comb begin
    state_d   = state_q;
    MUX_SEL   = SEL_CLEAR;
    PWM_OUT   = 1'b0;
    CYCLE_END = 1'b0;
    case (state_q)
      IDLE: begin
        if (EN && loaded_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        MUX_SEL   = at_wrap ? SEL_CLEAR : SEL_INCR;
        CYCLE_END = at_wrap;
        PWM_OUT   = (count_q < act_duty_q);
        // EN is only honoured at the wrap so the current period completes.
        if (at_wrap && !EN) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed bench for pwm_ctrl with a behavioural datapath.
module tb_pwm_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic [W-1:0] cfg_duty;
  logic [W-1:0] counter_d;
  logic [W-1:0] counter_q;
  logic [1:0]   mux_sel;
  logic         pwm_out;
  logic         cycle_end;
  logic         state_dbg;

  int total = 0;
  int bad   = 0;

  // Clock / datapath model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign counter_d = (mux_sel == 2'b01) ? counter_q + 8'd1 : 8'd0;

  pwm_ctrl #(.WIDTH(W)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .EN         (en),
    .CFG_VALID  (cfg_valid),
    .CFG_READY  (cfg_ready),
    .CFG_PERIOD (cfg_period),
    .CFG_DUTY   (cfg_duty),
    .COUNTER_D  (counter_d),
    .COUNTER_Q  (counter_q),
    .MUX_SEL    (mux_sel),
    .PWM_OUT    (pwm_out),
    .CYCLE_END  (cycle_end),
    .state_dbg  (state_dbg)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [W-1:0] p, input logic [W-1:0] d);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    tick();
    cfg_valid  = 1'b0;
  endtask

  // Advance past the next wrap edge; lands on count 0 of the following period.
  task automatic wait_wrap();
    int n = 0;
    while (cycle_end !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("wrap_seen", cycle_end, 1);
    tick();
  endtask

  task automatic check_cycle(input string tag, input logic [W-1:0] c, input logic p,
                             input logic [1:0] m, input logic ce);
    check({tag, "_cnt"}, counter_q, c);
    check({tag, "_pwm"}, pwm_out, p);
    check({tag, "_mux"}, mux_sel, m);
    check({tag, "_ce"},  cycle_end, ce);
  endtask

  logic [W-1:0] t2_cnt [5] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
  logic         t2_pwm [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0]   t2_mux [5] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
  logic         t2_ce  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic         t3_pwm [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst_n      = 1'b0;
    en         = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;

    // 1: reset state, then stays idle without a config
    tick();
    tick();
    check("rst_cnt", counter_q, 0);
    check("rst_mux", mux_sel, 0);
    check("rst_pwm", pwm_out, 0);
    check("rst_ce", cycle_end, 0);
    check("rst_rdy", cfg_ready, 1);
    check("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("idle_state", state_dbg, 0);
    check("idle_cnt", counter_q, 0);

    // 2: P=4 D=2, two full periods
    offer(8'd4, 8'd2);
    check("t2_rdy_busy", cfg_ready, 0);
    tick();
    check("t2_still_idle", state_dbg, 0);
    tick();
    check("t2_run", state_dbg, 1);
    for (int i = 0; i < 10; i++) begin
      check_cycle("t2", t2_cnt[i % 5], t2_pwm[i % 5], t2_mux[i % 5], t2_ce[i % 5]);
      tick();
    end

    // 3: offer D=4 at count 1, second offer stalled
    tick();
    check("t3_cnt1", counter_q, 1);
    cfg_valid  = 1'b1;
    cfg_period = 8'd4;
    cfg_duty   = 8'd4;
    tick();
    cfg_duty = 8'd0;
    check("t3_rdy_c2", cfg_ready, 0);
    check("t3_pwm_c2", pwm_out, 0);
    tick();
    check("t3_rdy_c3", cfg_ready, 0);
    check("t3_pwm_c3", pwm_out, 0);
    tick();
    check("t3_rdy_c4", cfg_ready, 0);
    check("t3_ce_c4", cycle_end, 1);
    cfg_valid = 1'b0;
    tick();
    check("t3_rdy_after", cfg_ready, 1);
    for (int i = 0; i < 5; i++) begin
      check("t3_cnt", counter_q, t2_cnt[i]);
      check("t3_pwm", pwm_out, t3_pwm[i]);
      tick();
    end
    check("t3_next_cnt", counter_q, 0);
    check("t3_next_pwm", pwm_out, 1);

    // 4a: D=0 -> always low
    offer(8'd4, 8'd0);
    wait_wrap();
    for (int i = 0; i < 5; i++) begin
      check("t4_d0_pwm", pwm_out, 0);
      tick();
    end
    // 4b: D=9 > P=4 -> always high
    offer(8'd4, 8'd9);
    wait_wrap();
    for (int i = 0; i < 5; i++) begin
      check("t4_d9_pwm", pwm_out, 1);
      tick();
    end
    // 4c: P=0 D=1
    offer(8'd0, 8'd1);
    wait_wrap();
    for (int i = 0; i < 4; i++) begin
      check_cycle("t4_p0", 8'd0, 1'b1, 2'b00, 1'b1);
      tick();
    end

    // 5: back to P=4 D=2, drop EN at count 2
    offer(8'd4, 8'd2);
    wait_wrap();
    check("t5_cnt0", counter_q, 0);
    tick();
    tick();
    check("t5_cnt2", counter_q, 2);
    en = 1'b0;
    tick();
    check_cycle("t5_c3", 8'd3, 1'b0, 2'b01, 1'b0);
    tick();
    check_cycle("t5_c4", 8'd4, 1'b0, 2'b00, 1'b1);
    tick();
    check("t5_idle", state_dbg, 0);
    check_cycle("t5_idle", 8'd0, 1'b0, 2'b00, 1'b0);
    tick();
    check("t5_idle2", state_dbg, 0);
    en = 1'b1;
    tick();
    check("t5_restart", state_dbg, 1);
    check("t5_restart_cnt", counter_q, 0);
    check("t5_restart_pwm", pwm_out, 1);

    // 6: reset mid-period at count 3
    tick();
    tick();
    tick();
    check("t6_cnt3", counter_q, 3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_cnt", counter_q, 0);
    check("t6_pwm", pwm_out, 0);
    check("t6_state", state_dbg, 0);
    check("t6_rdy", cfg_ready, 1);
    for (int i = 0; i < 3; i++) tick();
    check("t6_no_restart", state_dbg, 0);
    offer(8'd2, 8'd1);
    tick();
    tick();
    check_cycle("t6_r0", 8'd0, 1'b1, 2'b01, 1'b0);
    tick();
    check_cycle("t6_r1", 8'd1, 1'b0, 2'b01, 1'b0);
    tick();
    check_cycle("t6_r2", 8'd2, 1'b0, 2'b00, 1'b1);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
